// File: rtl/ch0_engine.sv
// ch0_engine: DMA channel 0 data mover between source and destination FIFOs
// Ports: wb_clk_i/wb_rst_i clock and sync active-high reset;
//   job_start/job_abort/job_swap job control in, job_busy/job_done/job_words status out;
//   m_reset0 FIFO clear; m_src_* source FIFO pop side; m_dst_* destination FIFO push side;
//   m_endn0 active-low end-of-job towards the channel.
module ch0_engine #(
    parameter int CNT_W = 24
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             job_start,
    input  logic             job_abort,
    input  logic             job_swap,
    output logic             job_busy,
    output logic             job_done,
    output logic [CNT_W-1:0] job_words,
    output logic             m_reset0,
    output logic             m_src_getn0,
    input  logic [63:0]      m_src0,
    input  logic             m_src_last0,
    input  logic             m_src_empty0,
    input  logic             m_src_almost_empty0,
    output logic             m_dst_putn0,
    output logic [63:0]      m_dst0,
    output logic             m_dst_last0,
    input  logic             m_dst_full0,
    input  logic             m_dst_almost_full0,
    output logic             m_endn0
);
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, FLUSH, DONE} state_t;
    state_t           r_state, w_nxt;
    logic [64:0]      r_sk0, r_sk1;
    logic [1:0]       r_cnt;
    logic             r_last_seen, r_swap, r_abt, r_done, r_endn;
    logic [CNT_W-1:0] r_words;
    logic             w_pop, w_push, w_unused;
    logic [64:0]      w_new;

    assign w_unused = &{1'b0, m_src_almost_empty0, m_dst_almost_full0};
    assign w_new    = {m_src_last0, r_swap ? {<<8{m_src0}} : m_src0};
    assign w_pop    = (r_state == RUN) && !m_src_empty0 && (r_cnt != 2'd2) && !r_last_seen;
    assign w_push   = (r_cnt != 2'd0) && !m_dst_full0;

    // r_abt remembers that CLEAR was entered by an abort, so CLEAR exits to IDLE
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    w_nxt = (job_start && !job_abort) ? CLEAR : IDLE;
            CLEAR:   w_nxt = (r_abt || job_abort) ? IDLE : RUN;
            RUN:     w_nxt = job_abort ? CLEAR : (w_pop && m_src_last0) ? FLUSH : RUN;
            FLUSH:   w_nxt = job_abort ? CLEAR : (w_push && r_cnt == 2'd1) ? DONE : FLUSH;
            DONE:    w_nxt = (job_abort || job_start) ? CLEAR : DONE;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= IDLE;
            r_sk0       <= '0;
            r_sk1       <= '0;
            r_cnt       <= '0;
            r_last_seen <= 1'b0;
            r_swap      <= 1'b0;
            r_abt       <= 1'b0;
            r_done      <= 1'b0;
            r_endn      <= 1'b1;
            r_words     <= '0;
        end else begin
            r_state <= w_nxt;
            r_abt   <= job_abort;
            r_done  <= (r_state == FLUSH) && (w_nxt == DONE);
            if ((r_state == FLUSH) && (w_nxt == DONE))
                r_endn <= 1'b0;
            else if (w_nxt == CLEAR)
                r_endn <= 1'b1;
            if ((w_nxt == CLEAR) && (r_state != CLEAR))
                r_swap <= job_swap;
            // the skid is discarded on the edge entering CLEAR, so CLEAR never pushes
            if (w_nxt == CLEAR) begin
                r_cnt       <= '0;
                r_last_seen <= 1'b0;
                r_words     <= '0;
            end else begin
                r_cnt <= r_cnt + {1'b0, w_pop} - {1'b0, w_push};
                if (w_pop && m_src_last0)
                    r_last_seen <= 1'b1;
                if (w_push && (r_words != '1))
                    r_words <= r_words + CNT_W'(1);
                // head refills from the second slot, or directly from the source when that is the next word
                if (w_push && (r_cnt == 2'd2))
                    r_sk0 <= r_sk1;
                else if (w_pop && ((r_cnt == 2'd0) || w_push))
                    r_sk0 <= w_new;
                if (w_pop && !w_push && (r_cnt == 2'd1))
                    r_sk1 <= w_new;
            end
        end
    end

    assign job_busy    = (r_state == CLEAR) || (r_state == RUN) || (r_state == FLUSH);
    assign job_done    = r_done;
    assign job_words   = r_words;
    assign m_reset0    = (r_state == CLEAR);
    assign m_src_getn0 = !w_pop;
    assign m_dst_putn0 = !w_push;
    assign m_dst0      = r_sk0[63:0];
    assign m_dst_last0 = r_sk0[64];
    assign m_endn0     = r_endn;
endmodule
